// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared encodings for the multicycle MIPS control unit.
// ALUOp codes, state codes, opcode/funct values and datapath select codes.
package mc_ctrl_pkg;

    localparam logic [3:0] ALU_NOP  = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_NOR  = 4'd7;
    localparam logic [3:0] ALU_XOR  = 4'd8;
    localparam logic [3:0] ALU_SRLV = 4'd9;
    localparam logic [3:0] ALU_SLLV = 4'd10;
    localparam logic [3:0] ALU_SRAV = 4'd11;
    localparam logic [3:0] ALU_LUI  = 4'd12;

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_EXEC   = 4'd2;
    localparam logic [3:0] S_IEXEC  = 4'd3;
    localparam logic [3:0] S_MEMADR = 4'd4;
    localparam logic [3:0] S_MEMRD  = 4'd5;
    localparam logic [3:0] S_MEMWB  = 4'd6;
    localparam logic [3:0] S_MEMWR  = 4'd7;
    localparam logic [3:0] S_RWB    = 4'd8;
    localparam logic [3:0] S_IWB    = 4'd9;
    localparam logic [3:0] S_BRANCH = 4'd10;
    localparam logic [3:0] S_JUMP   = 4'd11;
    localparam logic [3:0] S_TRAP   = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_4    = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_IMM2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_A      = 2'b11;

    localparam logic [1:0] DST_RT = 2'b00;
    localparam logic [1:0] DST_RD = 2'b01;
    localparam logic [1:0] DST_RA = 2'b10;

    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_PC     = 2'b10;

endpackage

// File: rtl/mc_aludec.sv
// mc_aludec: combinational Op/Funct to ALUOp mapper.
// Flags encodings that have no ALU operation as illegal.
module mc_aludec
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] i_op,
    input  logic [5:0] i_funct,
    output logic [3:0] o_aluop,
    output logic       o_legal
);

    always_comb begin
        o_aluop = ALU_NOP;
        o_legal = 1'b1;
        if (i_op == OP_RTYPE) begin
            case (i_funct)
                FN_ADD:  o_aluop = ALU_ADD;
                FN_SUB:  o_aluop = ALU_SUB;
                FN_AND:  o_aluop = ALU_AND;
                FN_OR:   o_aluop = ALU_OR;
                FN_SLT:  o_aluop = ALU_SLT;
                FN_SLTU: o_aluop = ALU_SLTU;
                FN_NOR:  o_aluop = ALU_NOR;
                FN_XOR:  o_aluop = ALU_XOR;
                FN_SLLV: o_aluop = ALU_SLLV;
                FN_SRLV: o_aluop = ALU_SRLV;
                FN_SRAV: o_aluop = ALU_SRAV;
                default: o_legal = 1'b0;
            endcase
        end else begin
            case (i_op)
                OP_ADDI: o_aluop = ALU_ADD;
                OP_SLTI: o_aluop = ALU_SLT;
                OP_ANDI: o_aluop = ALU_AND;
                OP_ORI:  o_aluop = ALU_OR;
                OP_LUI:  o_aluop = ALU_LUI;
                default: o_legal = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle MIPS control FSM driving the shared-ALU datapath.
// Define MC_CTRL_ILLEGAL_TRAP_EN to trap illegal instructions in S_TRAP.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter logic [3:0] RESET_STATE = S_FETCH
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       IorD,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output logic       EXTOp,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [3:0] ALUOp,
    output logic [1:0] PCSource,
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    output logic       illegal_o,
`endif
    output logic [3:0] state_o
);

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    localparam logic [3:0] S_ILLEGAL = S_TRAP;
`else
    localparam logic [3:0] S_ILLEGAL = S_FETCH;
`endif

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic [3:0] w_aluop;
    logic       w_legal;

    mc_aludec u_aludec (
        .i_op    (Op),
        .i_funct (Funct),
        .o_aluop (w_aluop),
        .o_legal (w_legal)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= RESET_STATE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH: w_next = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW:
                        w_next = S_MEMADR;
                    OP_RTYPE:
                        w_next = (Funct == FN_JR) ? S_JUMP : S_EXEC;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_LUI:
                        w_next = S_IEXEC;
                    OP_BEQ, OP_BNE:
                        w_next = S_BRANCH;
                    OP_J, OP_JAL:
                        w_next = S_JUMP;
                    default:
                        w_next = S_ILLEGAL;
                endcase
            end
            S_EXEC:   w_next = w_legal ? S_RWB : S_ILLEGAL;
            S_IEXEC:  w_next = S_IWB;
            S_MEMADR: w_next = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  w_next = S_MEMWB;
            // Trap is sticky only when the feature is built in
            S_TRAP:   w_next = S_ILLEGAL;
            default:  w_next = S_FETCH;
        endcase
    end

    always_comb begin
        PCWrite  = 1'b0;
        IRWrite  = 1'b0;
        IorD     = 1'b0;
        MemWrite = 1'b0;
        RegWrite = 1'b0;
        RegDst   = DST_RT;
        MemtoReg = WB_ALUOUT;
        EXTOp    = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = SRCB_B;
        ALUOp    = ALU_NOP;
        PCSource = PCSRC_ALU;
        case (r_state)
            S_FETCH: begin
                IRWrite = 1'b1;
                ALUSrcB = SRCB_4;
                ALUOp   = ALU_ADD;
                PCWrite = 1'b1;
            end
            S_DECODE: begin
                ALUSrcB = SRCB_IMM2;
                EXTOp   = 1'b1;
                ALUOp   = ALU_ADD;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = w_aluop;
            end
            S_RWB: begin
                RegWrite = 1'b1;
                RegDst   = DST_RD;
            end
            S_IEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                EXTOp   = (Op == OP_ADDI) || (Op == OP_SLTI);
                ALUOp   = w_aluop;
            end
            S_IWB: RegWrite = 1'b1;
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                EXTOp   = 1'b1;
                ALUOp   = ALU_ADD;
            end
            S_MEMRD: IorD = 1'b1;
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = WB_MDR;
            end
            S_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA  = 1'b1;
                ALUOp    = ALU_SUB;
                PCSource = PCSRC_ALUOUT;
                PCWrite  = (Op == OP_BNE) ? ~Zero : Zero;
            end
            S_JUMP: begin
                PCWrite = 1'b1;
                if (Op == OP_RTYPE) begin
                    PCSource = PCSRC_A;
                end else begin
                    PCSource = PCSRC_JUMP;
                    if (Op == OP_JAL) begin
                        RegWrite = 1'b1;
                        RegDst   = DST_RA;
                        MemtoReg = WB_PC;
                    end
                end
            end
            default: ;
        endcase
        if (rst) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
            MemWrite = 1'b0;
            ALUOp    = ALU_NOP;
        end
    end

    assign state_o = r_state;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    assign illegal_o = (r_state == S_TRAP);
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: table-driven scoreboard bench for mc_ctrl plus hand-written
// sequences for select codes, mid-instruction reset and illegal encodings.
module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;
    logic       PCWrite, IRWrite, IorD, MemWrite, RegWrite;
    logic [1:0] RegDst, MemtoReg, ALUSrcB, PCSource;
    logic       EXTOp, ALUSrcA;
    logic [3:0] ALUOp, state_o;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    logic       illegal_o;
`endif

    mc_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .Op       (Op),
        .Funct    (Funct),
        .Zero     (Zero),
        .PCWrite  (PCWrite),
        .IRWrite  (IRWrite),
        .IorD     (IorD),
        .MemWrite (MemWrite),
        .RegWrite (RegWrite),
        .RegDst   (RegDst),
        .MemtoReg (MemtoReg),
        .EXTOp    (EXTOp),
        .ALUSrcA  (ALUSrcA),
        .ALUSrcB  (ALUSrcB),
        .ALUOp    (ALUOp),
        .PCSource (PCSource),
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        .illegal_o(illegal_o),
`endif
        .state_o  (state_o)
    );

    always #5 clk = ~clk;

    // Per-cycle expectations, cycle 0 in the top nibble.
    // we nibble = {PCWrite, IRWrite, RegWrite, MemWrite}
    typedef struct packed {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic [2:0]  len;
        logic [19:0] st;
        logic [19:0] alu;
        logic [19:0] we;
    } vec_t;

    typedef struct packed {
        logic [3:0] st;
        logic [3:0] alu;
        logic [3:0] we;
    } exp_t;

    vec_t tbl[32];
    int   ntbl;
    exp_t sbq[$];
    int   total;
    int   bad;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [5:0] op, input logic [5:0] fn,
                                input logic z, input logic [2:0] len,
                                input logic [19:0] st,
                                input logic [19:0] alu,
                                input logic [19:0] we);
        vec_t v;
        v.op = op; v.fn = fn; v.z = z; v.len = len;
        v.st = st; v.alu = alu; v.we = we;
        return v;
    endfunction

    task automatic add(input vec_t v);
        tbl[ntbl] = v;
        ntbl++;
    endtask

    task automatic add_r(input logic [5:0] fn, input logic [3:0] a);
        add(mk(6'h00, fn, 1'b0, 3'd4, 20'h01280, {8'h11, a, 8'h00},
               20'hC0020));
    endtask

    task automatic add_i(input logic [5:0] op, input logic [3:0] a);
        add(mk(op, 6'h00, 1'b0, 3'd4, 20'h01390, {8'h11, a, 8'h00},
               20'hC0020));
    endtask

    task automatic add_b(input logic [5:0] op, input logic z,
                         input logic [3:0] w);
        add(mk(op, 6'h00, z, 3'd3, 20'h01A00, 20'h11200,
               {8'hC0, w, 8'h00}));
    endtask

    task automatic add_j(input logic [5:0] op, input logic [5:0] fn,
                         input logic [3:0] w);
        add(mk(op, fn, 1'b0, 3'd3, 20'h01B00, 20'h11000,
               {8'hC0, w, 8'h00}));
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        exp_t g;
        Op = v.op; Funct = v.fn; Zero = v.z;
        for (int k = 0; k < int'(v.len); k++) begin
            e.st  = v.st[19-4*k -: 4];
            e.alu = v.alu[19-4*k -: 4];
            e.we  = v.we[19-4*k -: 4];
            sbq.push_back(e);
        end
        for (int k = 0; k < int'(v.len); k++) begin
            #1;
            g = {state_o, ALUOp, PCWrite, IRWrite, RegWrite, MemWrite};
            e = sbq.pop_front();
            chk($sformatf("vec op=%02h fn=%02h z=%0b cyc%0d",
                          v.op, v.fn, v.z, k), {20'd0, g}, {20'd0, e});
            @(negedge clk);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    task automatic trap_hold(input string nm);
        nxt();
        chk({nm, " trap"}, {state_o, illegal_o, PCWrite, IRWrite,
            RegWrite, MemWrite, ALUOp}, {4'd12, 5'b10000, 4'd0});
        nxt();
        chk({nm, " trap hold"}, {state_o, illegal_o}, {4'd12, 1'b1});
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk({nm, " trap exit"}, {state_o, illegal_o}, {4'd0, 1'b0});
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        total = 0; bad = 0; ntbl = 0;
        rst = 1'b1; Op = 6'h00; Funct = 6'h00; Zero = 1'b0;

        add(mk(6'h23, 6'h00, 1'b0, 3'd5, 20'h01456, 20'h11100,
               20'hC0002));
        add(mk(6'h2B, 6'h00, 1'b0, 3'd4, 20'h01470, 20'h11100,
               20'hC0010));
        add_r(6'h20, 4'd1);  add_r(6'h22, 4'd2);  add_r(6'h24, 4'd3);
        add_r(6'h25, 4'd4);  add_r(6'h2A, 4'd5);  add_r(6'h2B, 4'd6);
        add_r(6'h27, 4'd7);  add_r(6'h26, 4'd8);  add_r(6'h06, 4'd9);
        add_r(6'h04, 4'd10); add_r(6'h07, 4'd11);
        add_i(6'h08, 4'd1);  add_i(6'h0A, 4'd5);  add_i(6'h0C, 4'd3);
        add_i(6'h0D, 4'd4);  add_i(6'h0F, 4'd12);
        add_b(6'h04, 1'b1, 4'h8); add_b(6'h04, 1'b0, 4'h0);
        add_b(6'h05, 1'b0, 4'h8); add_b(6'h05, 1'b1, 4'h0);
        add_j(6'h02, 6'h00, 4'h8); add_j(6'h03, 6'h00, 4'hA);
        add_j(6'h00, 6'h08, 4'h8);

        @(negedge clk);
        @(negedge clk);
        #1;
        chk("reset hold", {state_o, PCWrite, IRWrite, RegWrite, MemWrite,
            ALUOp}, 12'h000);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < ntbl; i++) run_vec(tbl[i]);

        // lw: select codes along the five-cycle path
        Op = 6'h23; Funct = 6'h00; Zero = 1'b0;
        #1;
        chk("fetch sel", {IorD, ALUSrcA, ALUSrcB, PCSource}, 6'b000100);
        nxt();
        chk("decode sel", {ALUSrcA, ALUSrcB, EXTOp, ALUOp},
            {1'b0, 2'd3, 1'b1, 4'd1});
        nxt();
        chk("lw memadr", {state_o, ALUSrcA, ALUSrcB, EXTOp, ALUOp},
            {4'd4, 1'b1, 2'd2, 1'b1, 4'd1});
        nxt();
        chk("lw memrd", {state_o, IorD, MemWrite}, {4'd5, 2'b10});
        nxt();
        chk("lw memwb", {state_o, RegWrite, MemtoReg, RegDst},
            {4'd6, 1'b1, 2'd1, 2'd0});
        @(negedge clk);

        // Branches: PCWrite follows Zero within the branch cycle
        Op = 6'h04; Zero = 1'b1;
        #1; nxt(); nxt();
        chk("beq taken", {state_o, ALUSrcA, ALUSrcB, ALUOp, PCSource,
            PCWrite}, {4'd10, 1'b1, 2'd0, 4'd2, 2'd1, 1'b1});
        Zero = 1'b0;
        #1;
        chk("beq not taken", {28'd0, state_o, PCWrite}, {28'd0, 4'd10, 1'b0});
        @(negedge clk);
        Op = 6'h05; Zero = 1'b0;
        #1; nxt(); nxt();
        chk("bne taken", {state_o, PCSource, PCWrite},
            {4'd10, 2'd1, 1'b1});
        Zero = 1'b1;
        #1;
        chk("bne not taken", {state_o, PCWrite}, {4'd10, 1'b0});
        @(negedge clk);

        // sllv
        Op = 6'h00; Funct = 6'h04; Zero = 1'b0;
        #1; nxt(); nxt();
        chk("sllv exec", {state_o, ALUSrcA, ALUSrcB, ALUOp},
            {4'd2, 1'b1, 2'd0, 4'd10});
        nxt();
        chk("sllv rwb", {state_o, RegWrite, RegDst, MemtoReg},
            {4'd8, 1'b1, 2'd1, 2'd0});
        @(negedge clk);

        // andi uses zero extension
        Op = 6'h0C; Funct = 6'h00;
        #1; nxt(); nxt();
        chk("andi iexec", {state_o, ALUSrcA, ALUSrcB, EXTOp, ALUOp},
            {4'd3, 1'b1, 2'd2, 1'b0, 4'd3});
        nxt();
        chk("andi iwb", {state_o, RegWrite, RegDst, MemtoReg},
            {4'd9, 1'b1, 2'd0, 2'd0});
        @(negedge clk);

        // jal, then confirm the return to fetch
        Op = 6'h03;
        #1; nxt(); nxt();
        chk("jal jump", {state_o, PCWrite, PCSource, RegWrite, RegDst,
            MemtoReg}, {4'd11, 1'b1, 2'd2, 1'b1, 2'd2, 2'd2});
        nxt();
        chk("jal next", {28'd0, state_o}, 32'd0);

        Op = 6'h00; Funct = 6'h08;
        #1; nxt(); nxt();
        chk("jr jump", {state_o, PCWrite, PCSource, RegWrite},
            {4'd11, 1'b1, 2'd3, 1'b0});
        @(negedge clk);

        // Reset lands in the middle of a store
        Op = 6'h2B; Funct = 6'h00;
        #1; nxt(); nxt(); nxt();
        chk("sw memwr", {state_o, MemWrite, IorD}, {4'd7, 2'b11});
        rst = 1'b1;
        #1;
        chk("rst in memwr", {MemWrite, PCWrite, IRWrite, RegWrite, ALUOp},
            8'h00);
        @(posedge clk);
        #1;
        chk("rst to fetch", {state_o, PCWrite, IRWrite, ALUOp}, 10'h000);
        @(negedge clk);
        rst = 1'b0;
        run_vec(mk(6'h02, 6'h00, 1'b0, 3'd3, 20'h01B00, 20'h11000,
                   20'hC0800));

        // Unlisted funct
        Op = 6'h00; Funct = 6'h21;
        #1; nxt(); nxt();
        chk("bad funct exec", {state_o, ALUOp, PCWrite, IRWrite, RegWrite,
            MemWrite}, {4'd2, 4'd0, 4'd0});
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        trap_hold("bad funct");
`else
        nxt();
        chk("bad funct next", {state_o, IRWrite}, {4'd0, 1'b1});
`endif

        // Unlisted opcode
        Op = 6'h3F; Funct = 6'h00;
        #1; nxt();
        chk("bad op decode", {state_o, PCWrite, IRWrite, RegWrite,
            MemWrite}, {4'd1, 4'd0});
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        trap_hold("bad op");
`else
        nxt();
        chk("bad op next", {state_o, IRWrite, RegWrite, MemWrite},
            {4'd0, 3'b100});
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multicycle MIPS control unit. It is the producing end of the ALUOp/Zero interface that the datapath ALU consumes.
- Decodes Op/Funct from the instruction register and sequences a shared ALU through FETCH/DECODE/EXEC/MEM/WB states.
- Drives all datapath enables and muxes; consumes ALU Zero for branches.
- Sits between the IR and the multicycle datapath (PC, IR, MDR, A/B/ALUOut registers, RF, unified memory).

Parameters:
- RESET_STATE, 4'd0 (S_FETCH): state entered on reset.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- Op  in  6  IR[31:26]
- Funct  in  6  IR[5:0]
- Zero  in  1  ALU zero flag, valid in S_BRANCH
- PCWrite  out  1  PC load enable
- IRWrite  out  1  IR load enable
- IorD  out  1  memory address select: 0=PC, 1=ALUOut
- MemWrite  out  1  memory write strobe
- RegWrite  out  1  register-file write enable
- RegDst  out  2  destination register: 00=rt, 01=rd, 10=$31
- MemtoReg  out  2  write-back source: 00=ALUOut, 01=MDR, 10=PC
- EXTOp  out  1  immediate extension: 1=sign, 0=zero
- ALUSrcA  out  1  ALU A input: 0=PC, 1=A register
- ALUSrcB  out  2  ALU B input: 00=B, 01=4, 10=ext imm, 11=ext imm<<2
- ALUOp  out  4  ALU operation code
- PCSource  out  2  next PC: 00=ALU result, 01=ALUOut, 10=jump target, 11=A register
- state_o  out  4  current state, for debug

Behaviour:
- States: S_FETCH, S_DECODE, S_EXEC, S_IEXEC, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_RWB, S_IWB, S_BRANCH, S_JUMP, S_TRAP.
- Outputs are a Moore function of the state, except PCWrite in S_BRANCH, which also depends on Zero.
- Outputs not listed for a state are 0 / ALU_NOP.
- S_FETCH:
  - IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUOp=ADD, PCSource=00, PCWrite=1.
  - Next: S_DECODE.
- S_DECODE:
  - ALUSrcA=0, ALUSrcB=11, EXTOp=1, ALUOp=ADD (branch target into ALUOut).
  - lw/sw → S_MEMADR; R-type (except jr) → S_EXEC; addi/andi/ori/slti/lui → S_IEXEC; beq/bne → S_BRANCH; j/jal/jr → S_JUMP; any other opcode → illegal handling (see Optional Feature).
- S_EXEC:
  - ALUSrcA=1, ALUSrcB=00, ALUOp from Funct: add→ADD, sub→SUB, and→AND, or→OR, slt→SLT, sltu→SLTU, nor→NOR, xor→XOR, sllv→SLLV, srlv→SRLV, srav→SRAV.
  - Unlisted Funct → illegal handling.
  - Next: S_RWB.
- S_RWB: RegWrite=1, RegDst=01, MemtoReg=00. Next: S_FETCH.
- S_IEXEC:
  - ALUSrcA=1, ALUSrcB=10.
  - addi: ADD, EXTOp=1. slti: SLT, EXTOp=1. andi: AND, EXTOp=0. ori: OR, EXTOp=0. lui: LUI, EXTOp=0.
  - Next: S_IWB.
- S_IWB: RegWrite=1, RegDst=00, MemtoReg=00. Next: S_FETCH.
- S_MEMADR: ALUSrcA=1, ALUSrcB=10, EXTOp=1, ALUOp=ADD. lw → S_MEMRD; sw → S_MEMWR.
- S_MEMRD: IorD=1. Next: S_MEMWB.
- S_MEMWB: RegWrite=1, RegDst=00, MemtoReg=01. Next: S_FETCH.
- S_MEMWR: IorD=1, MemWrite=1. Next: S_FETCH.
- S_BRANCH:
  - ALUSrcA=1, ALUSrcB=00, ALUOp=SUB, PCSource=01.
  - PCWrite = Zero for beq, !Zero for bne.
  - Next: S_FETCH.
- S_JUMP:
  - PCWrite=1; PCSource=11 for jr, 10 for j/jal.
  - jal also: RegWrite=1, RegDst=10, MemtoReg=10. PC already holds PC+4 at this point, so $31 gets the return address.
  - Next: S_FETCH.
- Latency in cycles: R-type 4, I-arith 4, lw 5, sw 4, beq/bne 3, j/jal/jr 3.
- Reset:
  - Synchronous: state ← RESET_STATE on the clk edge with rst=1; a reset mid-instruction aborts it.
  - While rst=1, all write enables (PCWrite, IRWrite, RegWrite, MemWrite) are forced 0 and ALUOp=NOP, regardless of state.
- Op/Funct are sampled only in S_DECODE/S_EXEC/S_IEXEC/S_MEMADR/S_BRANCH/S_JUMP. IR is stable in all of these because IRWrite=1 only in S_FETCH.
- ALUOp codes: NOP=0, ADD=1, SUB=2, AND=3, OR=4, SLT=5, SLTU=6, NOR=7, XOR=8, SRLV=9, SLLV=10, SRAV=11, LUI=12.

Optional Feature:
- Macro MC_CTRL_ILLEGAL_TRAP_EN.
- Defined: an illegal Op/Funct moves to S_TRAP. S_TRAP holds all outputs inactive and stays until rst. Adds output illegal_o (1 bit), =1 only in S_TRAP.
- Undefined: an illegal instruction executes as NOP, going directly S_DECODE/S_EXEC → S_FETCH with no writes; illegal_o is absent.

Decomposition:
- Shared encode-definition include holds: ALUOp codes, state encodings, opcode/funct constants, and ALUSrcB/PCSource/RegDst/MemtoReg select codes.
- One natural sub-module: mc_aludec, a combinational Funct/Op → ALUOp mapper used by S_EXEC and S_IEXEC.

Test Plan:
- lw $t0,8($s0), s0=0x100 → states FETCH, DECODE, MEMADR, MEMRD, MEMWB (5 cycles); in MEMADR ALUOp=1, ALUSrcB=10; in MEMWB RegWrite=1, MemtoReg=01.
- beq with Zero=1, then again with Zero=0 → both 3 cycles; S_BRANCH ALUOp=2; PCWrite=1 with PCSource=01 in the first case, PCWrite=0 in the second; bne inverts.
- R-type Funct=0x04 (sllv) → S_EXEC ALUOp=10; S_RWB RegDst=01, RegWrite=1.
- jal → S_JUMP PCWrite=1, PCSource=10, RegWrite=1, RegDst=10, MemtoReg=10; next state S_FETCH.
- rst asserted during S_MEMWR → MemWrite=0 that cycle; state=S_FETCH after the edge.
- Op=0x3F: with MC_CTRL_ILLEGAL_TRAP_EN → S_TRAP, illegal_o=1 until rst. Without the macro → back to S_FETCH after DECODE with no writes.
